// File: rtl/cla_accum.sv
// Registered carry-lookahead adder/subtractor with an internal accumulator.
// Four-bit lookahead groups are joined by a second-level lookahead carry unit.
module cla_accum #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  localparam int GROUPS = WIDTH / 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              cin_eff;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS:0]   grp_c;
  logic [WIDTH-1:0]  bit_c;
  logic [WIDTH-1:0]  sum;
  logic              ovf_next;

  // SUB forms a - b as a + ~b + 1; ACC adds operand a onto the accumulator.
  always_comb begin
    x       = a;
    y       = b;
    cin_eff = cin;
    case (op)
      OP_SUB: begin
        y       = ~b;
        cin_eff = 1'b1;
      end
      OP_ACC: begin
        x = acc;
        y = a;
      end
      default: ;
    endcase
  end

  assign p = x ^ y;
  assign g = x & y;

  always_comb begin
    for (int k = 0; k < GROUPS; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Each group carry is a flat sum of products over all lower groups,
  // so no carry has to pass through another group's carry output.
  always_comb begin
    logic c_acc;
    logic prop;
    grp_c[0] = cin_eff;
    for (int k = 1; k <= GROUPS; k++) begin
      c_acc = 1'b0;
      prop  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        c_acc = c_acc | (prop & grp_g[j]);
        prop  = prop & grp_p[j];
      end
      grp_c[k] = c_acc | (prop & cin_eff);
    end
  end

  // Bit carries ripple only inside a group, seeded by that group's carry-in.
  always_comb begin
    logic c_bit;
    for (int k = 0; k < GROUPS; k++) begin
      c_bit = grp_c[k];
      for (int i = 0; i < 4; i++) begin
        bit_c[4*k+i] = c_bit;
        c_bit        = g[4*k+i] | (p[4*k+i] & c_bit);
      end
    end
  end

  assign sum      = p ^ bit_c;
  assign ovf_next = bit_c[WIDTH-1] ^ grp_c[GROUPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      result     <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (op == OP_CLR) begin
          result     <= '0;
          cout       <= 1'b0;
          ovf        <= 1'b0;
          ovf_sticky <= 1'b0;
          acc        <= '0;
        end else begin
          result <= sum;
          cout   <= grp_c[GROUPS];
          ovf    <= ovf_next;
          if (op == OP_ACC) begin
            acc <= sum;
            if (ovf_next) ovf_sticky <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_accum.sv
// Self-checking bench for cla_accum: directed 16-bit vectors with hand-computed
// results, then a random sweep of 4-, 8- and 32-bit instances against a model.
module tb_cla_accum;

  logic clk = 1'b0;
  logic reset;

  logic        in_valid;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        ovf_sticky;
  logic [15:0] acc;

  logic        sw_valid;
  logic [1:0]  sw_op;
  logic [31:0] sw_a;
  logic [31:0] sw_b;
  logic        sw_cin;

  logic        v4, c4, o4, s4;
  logic [3:0]  r4, acc4;
  logic        v8, c8, o8, s8;
  logic [7:0]  r8, acc8;
  logic        v32, c32, o32, s32;
  logic [31:0] r32, acc32;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  always #5 clk = ~clk;

  cla_accum #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .result(result), .cout(cout), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .acc(acc)
  );

  cla_accum #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .op(sw_op), .a(sw_a[3:0]),
    .b(sw_b[3:0]), .cin(sw_cin), .out_valid(v4), .result(r4), .cout(c4),
    .ovf(o4), .ovf_sticky(s4), .acc(acc4)
  );

  cla_accum #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .op(sw_op), .a(sw_a[7:0]),
    .b(sw_b[7:0]), .cin(sw_cin), .out_valid(v8), .result(r8), .cout(c8),
    .ovf(o8), .ovf_sticky(s8), .acc(acc8)
  );

  cla_accum #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .op(sw_op), .a(sw_a),
    .b(sw_b), .cin(sw_cin), .out_valid(v32), .result(r32), .cout(c32),
    .ovf(o32), .ovf_sticky(s32), .acc(acc32)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one main-DUT request, let the edge take it, then settle past the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] o,
                               input logic [15:0] av, input logic [15:0] bv,
                               input logic c);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
    cin      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkMain(input string tag, input logic v, input logic [15:0] r,
                           input logic c, input logic o, input logic s,
                           input logic [15:0] ac);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, " result"}, 32'(result), 32'(r));
    checkOutput({tag, " cout"}, 32'(cout), 32'(c));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(o));
    checkOutput({tag, " sticky"}, 32'(ovf_sticky), 32'(s));
    checkOutput({tag, " acc"}, 32'(acc), 32'(ac));
  endtask

  function automatic exp_t model(input int w, input logic [1:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] accv, input logic c);
    logic [63:0] mask, xv, yv, s;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, av} & mask;
    yv   = {32'd0, bv} & mask;
    if (o == SUB) begin
      yv = ~yv & mask;
      c  = 1'b1;
    end else if (o == ACC) begin
      yv = xv;
      xv = {32'd0, accv} & mask;
    end
    s      = xv + yv + {63'd0, c};
    e.res  = 32'(s & mask);
    e.cout = s[w];
    e.ovf  = (xv[w-1] == yv[w-1]) && (s[w-1] != xv[w-1]);
    if (o == CLR) e = '0;
    return e;
  endfunction

  initial begin
    int          widths [3] = '{4, 8, 32};
    logic [31:0] macc   [3];
    logic        mstk   [3];
    exp_t        e      [3];

    sw_valid = 1'b0;
    sw_op    = ADD;
    sw_a     = '0;
    sw_b     = '0;
    sw_cin   = 1'b0;

    // Reset held for two cycles while a request is presented.
    reset = 1'b1;
    applyStimulus(1'b1, ADD, 16'h0001, 16'h0001, 1'b0);
    checkMain("reset1", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, ADD, 16'h0001, 16'h0001, 1'b0);
    checkMain("reset2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    applyStimulus(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    checkMain("post_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

    applyStimulus(1'b1, ADD, 16'hFFFF, 16'h0001, 1'b0);
    checkMain("add_wrap", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, ADD, 16'h7FFF, 16'h0001, 1'b0);
    checkMain("add_ovf", 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, ADD, 16'hFFFF, 16'h0000, 1'b1);
    checkMain("add_cin_prop", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, SUB, 16'h0005, 16'h0007, 1'b0);
    checkMain("sub_borrow", 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, SUB, 16'h8000, 16'h0001, 1'b0);
    checkMain("sub_ovf", 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16'h0000);

    applyStimulus(1'b1, ACC, 16'h4000, 16'h1234, 1'b0);
    checkMain("acc1", 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h4000);
    applyStimulus(1'b1, ACC, 16'h4000, 16'h1234, 1'b0);
    checkMain("acc2", 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8000);
    applyStimulus(1'b1, ACC, 16'h4000, 16'h1234, 1'b0);
    checkMain("acc3", 1'b1, 16'hC000, 1'b0, 1'b0, 1'b1, 16'hC000);
    applyStimulus(1'b1, ACC, 16'h4000, 16'h1234, 1'b0);
    checkMain("acc4", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000);

    applyStimulus(1'b0, ACC, 16'h4000, 16'h0000, 1'b0);
    checkMain("idle_a", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b1, ADD, 16'h0001, 16'h0002, 1'b0);
    checkMain("add_mid", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, ADD, 16'h0100, 16'h0100, 1'b0);
    checkMain("idle_hold", 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000);

    applyStimulus(1'b1, ACC, 16'h0005, 16'h0000, 1'b1);
    checkMain("acc_cin", 1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0006);
    applyStimulus(1'b1, CLR, 16'hFFFF, 16'hFFFF, 1'b1);
    checkMain("clr", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, ADD, 16'h1111, 16'h1111, 1'b0);
    checkMain("clr_idle1", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, ADD, 16'h1111, 16'h1111, 1'b0);
    checkMain("clr_idle2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Width sweep; the main DUT stays idle and the sweep models start from reset.
    for (int k = 0; k < 3; k++) begin
      macc[k] = '0;
      mstk[k] = 1'b0;
    end
    for (int i = 0; i < 1000; i++) begin
      sw_valid = ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0;
      sw_op    = 2'($urandom_range(0, 2));
      sw_a     = $urandom;
      sw_b     = $urandom;
      sw_cin   = 1'($urandom_range(0, 1));
      if (i % 40 == 0) begin
        sw_valid = 1'b1;
        sw_op    = ((i / 40) % 2 == 0) ? ADD : ACC;
        sw_a     = 32'hFFFF_FFFF;
        sw_b     = 32'h0000_0000;
        sw_cin   = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (sw_valid) begin
          e[k] = model(widths[k], sw_op, sw_a, sw_b, macc[k], sw_cin);
          if (sw_op == ACC) begin
            macc[k] = e[k].res;
            if (e[k].ovf) mstk[k] = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      checkOutput("w4 valid", 32'(v4), 32'(sw_valid));
      checkOutput("w4 result", 32'(r4), e[0].res);
      checkOutput("w4 cout", 32'(c4), 32'(e[0].cout));
      checkOutput("w4 ovf", 32'(o4), 32'(e[0].ovf));
      checkOutput("w4 acc", 32'(acc4), macc[0]);
      checkOutput("w4 sticky", 32'(s4), 32'(mstk[0]));
      checkOutput("w8 result", 32'(r8), e[1].res);
      checkOutput("w8 cout", 32'(c8), 32'(e[1].cout));
      checkOutput("w8 ovf", 32'(o8), 32'(e[1].ovf));
      checkOutput("w8 acc", 32'(acc8), macc[1]);
      checkOutput("w8 sticky", 32'(s8), 32'(mstk[1]));
      checkOutput("w32 valid", 32'(v32), 32'(sw_valid));
      checkOutput("w32 result", r32, e[2].res);
      checkOutput("w32 cout", 32'(c32), 32'(e[2].cout));
      checkOutput("w32 ovf", 32'(o32), 32'(e[2].ovf));
      checkOutput("w32 acc", acc32, macc[2]);
      checkOutput("w32 sticky", 32'(s32), 32'(mstk[2]));
    end
    sw_valid = 1'b0;

    // Load the accumulator, then CLR alongside reset: reset wins with the same zero state.
    applyStimulus(1'b1, ACC, 16'h7FFF, 16'h0000, 1'b1);
    checkMain("acc_preload", 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8000);
    reset = 1'b1;
    applyStimulus(1'b1, CLR, 16'h0000, 16'h0000, 1'b0);
    checkMain("clr_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    applyStimulus(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    checkMain("after_clr_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_accum.md
# cla_accum

Parametrised carry-lookahead adder/subtractor with a registered result and an internal accumulator, built from 4-bit lookahead groups joined by a second-level lookahead unit. It replaces fixed 4-bit adders in the stopwatch datapath wherever wider counts, subtraction or running totals are needed. Results come out one clock after a valid input. The block provides carry, signed-overflow and sticky-overflow status.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4. There are WIDTH/4 lookahead groups.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operation request, sampled each rising edge.
- `op` input, 2 bits: operation select. 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B. Ignored by ACC and CLR.
- `cin` input, 1 bit: carry-in for ADD and ACC. Ignored by SUB and CLR.
- `out_valid` output, 1 bit: `result` and flags are valid this cycle.
- `result` output, WIDTH bits: registered result.
- `cout` output, 1 bit: carry out of the MSB group.
- `ovf` output, 1 bit: two's-complement overflow of this result.
- `ovf_sticky` output, 1 bit: set by any overflowing ACC; cleared only by CLR or reset.
- `acc` output, WIDTH bits: current accumulator value.

## Operation
- Datapath: per-bit p = x^y, g = x&y. Each 4-bit group produces group P and G. A second-level lookahead produces all group carries from `cin_eff`.
- No ripple chain longer than one group.
- Operand selection:
  - ADD: x=a, y=b, cin_eff=cin.
  - SUB: x=a, y=~b, cin_eff=1, giving a-b. `cout`=1 means no borrow.
  - ACC: x=acc, y=a, cin_eff=cin. The sum is also written into `acc`.
  - CLR: `acc`←0 and `ovf_sticky`←0. `result`=0, `cout`=0, `ovf`=0.
- Overflow: `ovf` = carry into MSB XOR carry out of MSB. For CLR, `ovf`=0.
- Arithmetic is modulo 2^WIDTH. The sum wraps and `cout` reports the lost carry.
- When `in_valid`=0:
  - `out_valid`←0.
  - `result`, `cout` and `ovf` hold their previous values.
  - `acc` and `ovf_sticky` hold.
- ADD and SUB never modify `acc` or `ovf_sticky`.
- Reset has priority over everything. Reset values:
  - `out_valid`=0, `result`=0, `cout`=0, `ovf`=0.
  - `ovf_sticky`=0, `acc`=0.
- A request sampled in the same cycle as reset is discarded.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear at `result`/`out_valid` after edge N and stay until the next accepted request.
- Throughput is one operation per cycle. There is no stall or ready signal, so every request with `in_valid`=1 is accepted.
- `acc` updates on the same edge as `result`. Back-to-back ACC operations therefore chain with no hazard: the ACC at edge N+1 uses the value written at edge N.
- ACC overflow at edge N sets `ovf_sticky` after edge N.
- CLR together with reset: reset wins, with the same end state.
- The critical path is the combinational path from operands through group P/G, second-level carries and group sums to the registers. Nothing is combinational from input to output.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `in_valid`=1, op=ADD. Required: all outputs 0 and `out_valid`=0 during reset and one cycle after.
- **ADD carry propagation** (WIDTH=16): a=16'hFFFF, b=16'h0001, cin=0. Required one cycle later: `result`=16'h0000, `cout`=1, `ovf`=0. Also a=16'h7FFF, b=16'h0001. Required: `result`=16'h8000, `ovf`=1, `cout`=0.
- **SUB:** a=5, b=7. Required: `result`=16'hFFFE, `cout`=0 (borrow). Also a=16'h8000, b=1. Required: `result`=16'h7FFF, `ovf`=1.
- **Back-to-back ACC:** ACC a=16'h4000, cin=0, four consecutive cycles, starting from `acc`=0.
  - `acc` reads 4000, 8000, C000, 0000.
  - `ovf` is 0, 1, 0, 0.
  - `cout` is 1 on the 4th operation.
  - `ovf_sticky` becomes 1 after the second operation and stays 1 through idle cycles and an intervening ADD.
- **CLR and idle hold:** after the ACC test, issue CLR, then two idle cycles.
  - Required: `acc`=0, `ovf_sticky`=0 and `result`=0 after CLR.
  - `out_valid` is 1 for exactly one cycle.
  - `result` holds 0 through the idle cycles.
- **Width sweep:** WIDTH=4, 8 and 32, with 1000 random ADD/SUB/ACC operations each. Compare `result`, `cout`, `ovf` and `acc` against a behavioural model. Include operands with a=all-ones and b=0 with cin=1 to exercise full group-carry propagation.
